// File: rtl/cellrv32_npu_activation_control.sv
// Activation control: reads accumulator rows for one activation instruction and
// steers each activated row to consecutive unified-buffer addresses.
package tpu_pkg;
  localparam int unsigned ACCUMULATOR_ADDRESS_WIDTH = 8;
  localparam int unsigned BUFFER_ADDRESS_WIDTH      = 10;
  localparam int unsigned CALC_LEN_WIDTH            = 16;
  localparam int unsigned OPCODE_WIDTH              = 8;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]              opcode;
    logic [CALC_LEN_WIDTH-1:0]            calc_len;
    logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
    logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_addr;
  } instruction_t;
endpackage

module cellrv32_npu_activation_control
  import tpu_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH     = 14,
  parameter int unsigned ACC_READ_LATENCY = 1,
  parameter int unsigned ACT_LATENCY      = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 enable_i,
  input  instruction_t                         inst_i,
  input  logic                                 inst_en_i,
  output logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr_o,
  output logic                                 acc_read_en_o,
  output logic [3:0]                           act_func_o,
  output logic                                 act_signed_o,
  output logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_addr_o,
  output logic                                 buff_wr_en_o,
  output logic                                 busy_o,
  output logic                                 resource_busy_o
);
  localparam int unsigned AW    = ACCUMULATOR_ADDRESS_WIDTH;
  localparam int unsigned BW    = BUFFER_ADDRESS_WIDTH;
  localparam int unsigned LW    = CALC_LEN_WIDTH;
  localparam int unsigned DELAY = ACC_READ_LATENCY + ACT_LATENCY;

  if (MATRIX_WIDTH == 0 || ACC_READ_LATENCY == 0 || ACT_LATENCY == 0) begin : g_param_check
    $error("activation control: MATRIX_WIDTH and latencies must be >= 1");
  end

  // Per-row payload; all fields are zero whenever valid is zero.
  typedef struct packed {
    logic          valid;
    logic          sgn;
    logic [3:0]    func;
    logic [BW-1:0] baddr;
  } row_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_n;
  logic [LW-1:0]           cnt_q, cnt_n;
  logic [AW-1:0]           acc_ptr_q, acc_ptr_n;
  logic [BW-1:0]           buf_ptr_q, buf_ptr_n;
  logic [3:0]              func_q, func_n;
  logic                    sgn_q, sgn_n;
  row_t                    issue_q, issue_n;
  logic [AW-1:0]           acc_addr_q, acc_addr_n;
  row_t [DELAY-1:0]        pipe_q, pipe_n;
  row_t [DELAY:0]          chain;
  logic [DELAY-1:0]        pipe_valid;
  logic                    busy_q, busy_n;
  logic                    rbusy_q, rbusy_n;
  logic                    unused_opcode_bits;

  assign unused_opcode_bits = ^inst_i.opcode[OPCODE_WIDTH-1:5];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       state_q <= IDLE;
    else if (enable_i) state_q <= state_n;
  end

  // Issue one row per RUN cycle; cnt_q counts rows still to issue after the current one.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    acc_ptr_n  = acc_ptr_q;
    buf_ptr_n  = buf_ptr_q;
    func_n     = func_q;
    sgn_n      = sgn_q;
    issue_n    = '0;
    acc_addr_n = '0;
    case (state_q)
      IDLE: begin
        if (inst_en_i && (inst_i.calc_len != '0)) begin
          state_n    = RUN;
          cnt_n      = inst_i.calc_len - LW'(1);
          func_n     = inst_i.opcode[3:0];
          sgn_n      = inst_i.opcode[4];
          issue_n    = '{valid: 1'b1, sgn: inst_i.opcode[4], func: inst_i.opcode[3:0],
                         baddr: inst_i.buff_addr};
          acc_addr_n = inst_i.acc_addr;
          acc_ptr_n  = inst_i.acc_addr + AW'(1);
          buf_ptr_n  = inst_i.buff_addr + BW'(1);
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n      = cnt_q - LW'(1);
          issue_n    = '{valid: 1'b1, sgn: sgn_q, func: func_q, baddr: buf_ptr_q};
          acc_addr_n = acc_ptr_q;
          acc_ptr_n  = acc_ptr_q + AW'(1);
          buf_ptr_n  = buf_ptr_q + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    chain   = {pipe_q, issue_q};
    pipe_n  = chain[DELAY-1:0];
    busy_n  = (state_n == RUN);
    rbusy_n = busy_n | (|pipe_valid);
  end

  for (genvar g = 0; g < DELAY; g++) begin : g_valid
    assign pipe_valid[g] = pipe_n[g].valid;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q      <= '0;
      acc_ptr_q  <= '0;
      buf_ptr_q  <= '0;
      func_q     <= '0;
      sgn_q      <= 1'b0;
      issue_q    <= '0;
      acc_addr_q <= '0;
      pipe_q     <= '0;
      busy_q     <= 1'b0;
      rbusy_q    <= 1'b0;
    end else if (enable_i) begin
      cnt_q      <= cnt_n;
      acc_ptr_q  <= acc_ptr_n;
      buf_ptr_q  <= buf_ptr_n;
      func_q     <= func_n;
      sgn_q      <= sgn_n;
      issue_q    <= issue_n;
      acc_addr_q <= acc_addr_n;
      pipe_q     <= pipe_n;
      busy_q     <= busy_n;
      rbusy_q    <= rbusy_n;
    end
  end

  assign acc_read_en_o   = issue_q.valid;
  assign acc_addr_o      = acc_addr_q;
  assign act_func_o      = pipe_q[ACC_READ_LATENCY-1].func;
  assign act_signed_o    = pipe_q[ACC_READ_LATENCY-1].sgn;
  assign buff_wr_en_o    = pipe_q[DELAY-1].valid;
  assign buff_addr_o     = pipe_q[DELAY-1].baddr;
  assign busy_o          = busy_q;
  assign resource_busy_o = rbusy_q;

endmodule

// File: tb/tb_cellrv32_npu_activation_control.sv
// Bench for cellrv32_npu_activation_control: per-cycle comparison against a schedule
// model indexed by enabled-cycle number, plus table-driven and hand-written cases.
module tb_cellrv32_npu_activation_control;
  import tpu_pkg::*;

  localparam int L = 1;
  localparam int D = 4;

  logic         clk, rstn, enable, inst_en;
  instruction_t inst;
  logic [7:0]   acc_addr;
  logic         acc_read_en;
  logic [3:0]   act_func;
  logic         act_signed;
  logic [9:0]   buff_addr;
  logic         buff_wr_en, busy, resource_busy;

  cellrv32_npu_activation_control #(
    .MATRIX_WIDTH(14), .ACC_READ_LATENCY(L), .ACT_LATENCY(D - L)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .inst_i(inst), .inst_en_i(inst_en),
    .acc_addr_o(acc_addr), .acc_read_en_o(acc_read_en), .act_func_o(act_func),
    .act_signed_o(act_signed), .buff_addr_o(buff_addr), .buff_wr_en_o(buff_wr_en),
    .busy_o(busy), .resource_busy_o(resource_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for each enabled-cycle index; missing entries mean all zero.
  typedef struct packed {
    bit       rd;
    bit [7:0] acc;
    bit [3:0] func;
    bit       sgn;
    bit       wr;
    bit [9:0] baddr;
    bit       busy;
    bit       rbusy;
  } exp_t;

  exp_t expm [int];
  int   ec;
  int   checks, failures;
  int   wr_count, first_w, last_w, last_acc;
  bit   busy_seen;

  function automatic exp_t get_exp(input int k);
    if (expm.exists(k)) return expm[k];
    return '0;
  endfunction

  function automatic instruction_t mk(input int len, input int a, input int b, input int op);
    instruction_t t;
    t.calc_len  = 16'(len);
    t.acc_addr  = 8'(a);
    t.buff_addr = 10'(b);
    t.opcode    = 8'(op);
    return t;
  endfunction

  // Instruction accepted at an edge: row r is read k+r, activated k+r+L, written k+r+D.
  task automatic model_accept(input int k, input instruction_t t);
    exp_t e;
    int n;
    n = int'(t.calc_len);
    for (int r = 0; r < n; r++) begin
      e = get_exp(k + r);
      e.rd = 1'b1; e.acc = 8'(int'(t.acc_addr) + r); e.busy = 1'b1;
      expm[k + r] = e;
      e = get_exp(k + r + L);
      e.func = t.opcode[3:0]; e.sgn = t.opcode[4];
      expm[k + r + L] = e;
      e = get_exp(k + r + D);
      e.wr = 1'b1; e.baddr = 10'(int'(t.buff_addr) + r);
      expm[k + r + D] = e;
    end
    for (int c = k; c < k + n + D; c++) begin
      e = get_exp(c);
      e.rbusy = 1'b1;
      expm[c] = e;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d, t=%0t)", name, act, req, ec, $time);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    e = get_exp(ec);
    check("acc_read_en", 32'(acc_read_en), 32'(e.rd));
    check("acc_addr", 32'(acc_addr), 32'(e.rd ? e.acc : 8'd0));
    check("act_func", 32'(act_func), 32'(e.func));
    check("act_signed", 32'(act_signed), 32'(e.sgn));
    check("buff_wr_en", 32'(buff_wr_en), 32'(e.wr));
    check("buff_addr", 32'(buff_addr), 32'(e.baddr));
    check("busy", 32'(busy), 32'(e.busy));
    check("resource_busy", 32'(resource_busy), 32'(e.rbusy));
  endtask

  task automatic clr_stats();
    wr_count = 0; first_w = -1; last_w = -1; last_acc = -1; busy_seen = 1'b0;
  endtask

  // Called at a negedge: drive, advance model, clock, then compare at the next negedge.
  task automatic step(input bit en, input bit ie, input instruction_t t);
    enable = en; inst_en = ie; inst = t;
    if (en) begin
      if (ie && t.calc_len != 16'd0 && !get_exp(ec).busy) model_accept(ec + 1, t);
      ec++;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (en) begin
      if (buff_wr_en) begin
        wr_count++;
        if (first_w < 0) first_w = int'(buff_addr);
        last_w = int'(buff_addr);
      end
      if (acc_read_en) last_acc = int'(acc_addr);
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, mk(0, 0, 0, 0));
  endtask

  typedef struct {
    int len; int acc; int buff; int op;
    int writes; int first_w; int last_w; int last_acc;
  } vec_t;

  vec_t vecs [5];
  bit [3:0] o_func [12];
  bit       o_rd [12], o_wr [12], o_rb [12];
  int       o_acc [12], o_baddr [12];
  instruction_t idle_i;

  initial begin
    vecs[0] = '{4, 10, 100, 8'h01, 4, 100, 103, 13};
    vecs[1] = '{0, 20, 200, 8'h03, 0, -1, -1, -1};
    vecs[2] = '{3, 254, 1022, 8'h05, 3, 1022, 0, 0};
    vecs[3] = '{1, 7, 500, 8'h1f, 1, 500, 500, 7};
    vecs[4] = '{5, 128, 3, 8'h17, 5, 3, 7, 132};
    idle_i = mk(0, 0, 0, 0);

    checks = 0; failures = 0; ec = 0;
    rstn = 1'b0; enable = 1'b0; inst_en = 1'b0; inst = idle_i;
    clr_stats();
    #1 check_outputs();
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    idle_steps(2);

    // Table of single instructions: write count, first/last addresses, last read address.
    foreach (vecs[i]) begin
      clr_stats();
      step(1'b1, 1'b1, mk(vecs[i].len, vecs[i].acc, vecs[i].buff, vecs[i].op));
      idle_steps(vecs[i].len + D + 3);
      check("tbl_writes", wr_count, vecs[i].writes);
      check("tbl_first_w", first_w, vecs[i].first_w);
      check("tbl_last_w", last_w, vecs[i].last_w);
      check("tbl_last_acc", last_acc, vecs[i].last_acc);
      check("tbl_busy_seen", 32'(busy_seen), 32'(vecs[i].len != 0));
    end

    // T1 exact cycle positions relative to the accept edge.
    clr_stats();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) step(1'b1, 1'b1, mk(4, 10, 100, 8'h01));
      else        step(1'b1, 1'b0, idle_i);
      o_rd[c] = acc_read_en; o_acc[c] = int'(acc_addr); o_func[c] = act_func;
      o_wr[c] = buff_wr_en; o_baddr[c] = int'(buff_addr); o_rb[c] = resource_busy;
    end
    // Index c holds cycle c+1 after acceptance.
    check("t1_rd_c1", 32'(o_rd[0]), 1);
    check("t1_acc_c1", o_acc[0], 10);
    check("t1_acc_c4", o_acc[3], 13);
    check("t1_rd_c5", 32'(o_rd[4]), 0);
    check("t1_func_c1", 32'(o_func[0]), 0);
    check("t1_func_c2", 32'(o_func[1]), 1);
    check("t1_func_c5", 32'(o_func[4]), 1);
    check("t1_func_c6", 32'(o_func[5]), 0);
    check("t1_wr_c4", 32'(o_wr[3]), 0);
    check("t1_wr_c5", 32'(o_wr[4]), 1);
    check("t1_baddr_c5", o_baddr[4], 100);
    check("t1_baddr_c8", o_baddr[7], 103);
    check("t1_wr_c9", 32'(o_wr[8]), 0);
    check("t1_rbusy_c8", 32'(o_rb[7]), 1);
    check("t1_rbusy_c9", 32'(o_rb[8]), 0);

    // T4: second instruction held during RUN, accepted only once IDLE is reached.
    clr_stats();
    step(1'b1, 1'b1, mk(4, 40, 300, 8'h01));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, mk(2, 60, 320, 8'h12));
    idle_steps(12);
    check("t4_writes", wr_count, 6);
    check("t4_last_w", last_w, 321);
    check("t4_last_acc", last_acc, 61);

    // T5: three stalled cycles mid-RUN.
    clr_stats();
    step(1'b1, 1'b1, mk(6, 90, 700, 8'h04));
    idle_steps(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(3, 1, 2, 8'h09));
    idle_steps(14);
    check("t5_writes", wr_count, 6);
    check("t5_first_w", first_w, 700);
    check("t5_last_w", last_w, 705);

    // T6: reset while row 2 of 6 is being read.
    step(1'b1, 1'b1, mk(6, 30, 30, 8'h03));
    idle_steps(2);
    check("t6_row2_addr", int'(acc_addr), 32);
    rstn = 1'b0;
    expm.delete();
    #1 check_outputs();
    @(posedge clk); @(negedge clk);
    check_outputs();
    rstn = 1'b1;
    clr_stats();
    idle_steps(12);
    check("t6_writes_after_reset", wr_count, 0);

    // Randomised traffic with stalls against the schedule model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 255))));
    idle_steps(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
